dither_stream_ctrl: RTL and testbench

- Controller/sequencer for the per-channel colour-quantisation datapath on the 24-bit video pixel stream.
- Tracks frame and line boundaries from `frame_start` and `visible`, and latches the dither mode only at frame start.
- Runs one error-diffusion accumulator per channel (R, G, B), cleared at every line start.
- Registers the quantised pixel with a fixed 1-cycle latency. Sits between the pixel source and the video output stage.

---
 rtl/dither_stream_ctrl.sv | 136 +++++++++++++
 tb/tb_dither_stream_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dither_stream_ctrl.sv
// Frame/line sequencer and per-channel quantiser for the 24-bit pixel stream.
// Bypass, threshold rounding or per-line error diffusion, 1-cycle registered.
module dither_stream_ctrl #(
    parameter int COLOR_W    = 8,
    parameter int KEEP_BITS  = 4,
    parameter int THRESHOLD  = 4,
    parameter int LINE_CNT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*COLOR_W-1:0]  data_in,
    input  logic                  visible,
    input  logic                  frame_start,
    input  logic [1:0]            SW,
    output logic [3*COLOR_W-1:0]  data_out,
    output logic                  visible_out,
    output logic [1:0]            mode_active,
    output logic [LINE_CNT_W-1:0] line_count
);

    localparam int RES_W = COLOR_W - KEEP_BITS;
    localparam logic [RES_W-1:0]      THR     = RES_W'(THRESHOLD);
    localparam logic [KEEP_BITS-1:0]  MSN_ONE = KEEP_BITS'(1);
    localparam logic [LINE_CNT_W-1:0] CNT_ONE = LINE_CNT_W'(1);

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_ROUND  = 2'b01;
    localparam logic [1:0] MODE_DIFF   = 2'b10;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'b00,
        BLANK      = 2'b01,
        LINE       = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_d;
    logic [LINE_CNT_W-1:0]   line_d;
    logic [RES_W-1:0]        err_q [3];
    logic [RES_W-1:0]        err_d [3];
    logic [3*COLOR_W-1:0]    data_d;
    logic [COLOR_W-1:0]      c, px, sat;
    logic [RES_W-1:0]        e_eff;

    function automatic logic [COLOR_W-1:0] round_px(
        input logic [COLOR_W-1:0] v
    );
        logic [KEEP_BITS-1:0] msn;
        logic [RES_W-1:0]     lsn;
        msn = v[COLOR_W-1 -: KEEP_BITS];
        lsn = v[RES_W-1:0];
        // Full-scale MSN never rounds up, so white stays white.
        if (lsn >= THR && msn != '1)
            return {msn + MSN_ONE, {RES_W{1'b0}}};
        return {msn, {RES_W{1'b0}}};
    endfunction

    function automatic logic [COLOR_W-1:0] sat_sum(
        input logic [COLOR_W-1:0] v,
        input logic [RES_W-1:0]   e
    );
        logic [COLOR_W:0] s;
        s = {1'b0, v} + {{(COLOR_W+1-RES_W){1'b0}}, e};
        return s[COLOR_W] ? '1 : s[COLOR_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        mode_d  = mode_active;
        line_d  = line_count;
        if (frame_start) begin
            state_d = BLANK;
            mode_d  = (SW == 2'b11) ? MODE_BYPASS : SW;
            line_d  = '0;
        end else begin
            unique case (state_q)
                WAIT_FRAME: state_d = WAIT_FRAME;
                BLANK: begin
                    if (visible) begin
                        state_d = LINE;
                        if (line_count != '1)
                            line_d = line_count + CNT_ONE;
                    end
                end
                LINE: if (!visible) state_d = BLANK;
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    always_comb begin
        data_d = '0;
        c      = '0;
        px     = '0;
        sat    = '0;
        e_eff  = '0;
        for (int i = 0; i < 3; i++) begin
            c     = data_in[i*COLOR_W +: COLOR_W];
            e_eff = (state_q == LINE) ? err_q[i] : '0;
            sat   = sat_sum(c, e_eff);
            err_d[i] = (mode_active == MODE_DIFF && visible)
                     ? sat[RES_W-1:0] : '0;
            case (mode_active)
                MODE_ROUND: px = visible ? round_px(c) : '0;
                MODE_DIFF:  px = visible
                               ? {sat[COLOR_W-1 -: KEEP_BITS], {RES_W{1'b0}}}
                               : '0;
                default:    px = c;
            endcase
            if (state_q == WAIT_FRAME)
                px = '0;
            data_d[i*COLOR_W +: COLOR_W] = px;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= WAIT_FRAME;
            mode_active <= MODE_BYPASS;
            line_count  <= '0;
            data_out    <= '0;
            visible_out <= 1'b0;
            for (int i = 0; i < 3; i++)
                err_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            mode_active <= mode_d;
            line_count  <= line_d;
            data_out    <= data_d;
            visible_out <= visible;
            for (int i = 0; i < 3; i++)
                err_q[i] <= err_d[i];
        end
    end

endmodule

// File: tb/tb_dither_stream_ctrl.sv
// Directed bench for dither_stream_ctrl.
// Inputs change 1ns after posedge; outputs checked 1ns after the next posedge.
module tb_dither_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic        visible;
    logic        frame_start;
    logic [1:0]  SW;
    logic [23:0] data_out;
    logic        visible_out;
    logic [1:0]  mode_active;
    logic [9:0]  line_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dither_stream_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .visible     (visible),
        .frame_start (frame_start),
        .SW          (SW),
        .data_out    (data_out),
        .visible_out (visible_out),
        .mode_active (mode_active),
        .line_count  (line_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fs, input logic vis,
                         input logic [23:0] px);
        frame_start = fs;
        visible     = vis;
        data_in     = px;
    endtask

    initial begin
        rst = 1'b0;
        SW  = 2'b00;
        drive(1'b0, 1'b0, 24'h0);
        cyc();
        cyc();
        check("rst_data", data_out, 24'h0);
        check("rst_vis", visible_out, 1'b0);
        check("rst_mode", mode_active, 2'b00);
        check("rst_line", line_count, 10'd0);

        // no frame_start yet: output held at zero
        rst = 1'b1;
        drive(1'b0, 1'b1, 24'hABCDEF);
        cyc();
        check("wait_data0", data_out, 24'h0);
        check("wait_line0", line_count, 10'd0);
        cyc();
        check("wait_data1", data_out, 24'h0);
        check("wait_mode1", mode_active, 2'b00);
        check("wait_line1", line_count, 10'd0);

        // round frame
        SW = 2'b01;
        drive(1'b1, 1'b0, 24'h0);
        cyc();
        check("rnd_mode", mode_active, 2'b01);
        drive(1'b0, 1'b1, 24'h3733F8);
        cyc();
        check("rnd_px0", data_out, 24'h4030F0);
        check("rnd_vis0", visible_out, 1'b1);
        check("rnd_line1", line_count, 10'd1);
        cyc();
        check("rnd_px1", data_out, 24'h4030F0);
        drive(1'b0, 1'b0, 24'h3733F8);
        cyc();
        check("rnd_blank", data_out, 24'h0);
        check("rnd_blank_vis", visible_out, 1'b0);

        // SW change mid-frame is ignored
        SW = 2'b10;
        drive(1'b0, 1'b1, 24'hFF0800);
        cyc();
        check("latch_mode", mode_active, 2'b01);
        check("latch_px", data_out, 24'hF01000);
        check("latch_line2", line_count, 10'd2);
        drive(1'b0, 1'b0, 24'h0);
        cyc();
        drive(1'b0, 1'b1, 24'h000000);
        cyc();
        check("three_lines", line_count, 10'd3);
        drive(1'b0, 1'b0, 24'h0);
        cyc();

        // error diffusion frame
        drive(1'b1, 1'b0, 24'h0);
        cyc();
        check("ed_mode", mode_active, 2'b10);
        check("ed_line0", line_count, 10'd0);
        drive(1'b0, 1'b1, 24'h080808);
        cyc();
        check("ed_c0", data_out, 24'h000000);
        cyc();
        check("ed_c1", data_out, 24'h101010);
        cyc();
        check("ed_c2", data_out, 24'h000000);
        cyc();
        check("ed_c3", data_out, 24'h101010);
        drive(1'b0, 1'b0, 24'h080808);
        cyc();
        check("ed_gap", data_out, 24'h0);
        drive(1'b0, 1'b1, 24'h080808);
        cyc();
        check("ed_restart0", data_out, 24'h000000);
        cyc();
        check("ed_restart1", data_out, 24'h101010);
        drive(1'b0, 1'b0, 24'h0);
        cyc();

        // saturation: 0xFF + 0xF clips to 0xFF, residual 0xF carries on
        drive(1'b0, 1'b1, 24'h0F0F0F);
        cyc();
        check("sat_0", data_out, 24'h000000);
        drive(1'b0, 1'b1, 24'hFFFFFF);
        cyc();
        check("sat_1", data_out, 24'hF0F0F0);
        drive(1'b0, 1'b1, 24'h010101);
        cyc();
        check("sat_err", data_out, 24'h101010);
        check("sat_line3", line_count, 10'd3);
        drive(1'b0, 1'b0, 24'h0);
        cyc();

        // frame_start with visible: old mode, counter cleared, state BLANK
        SW = 2'b01;
        drive(1'b1, 1'b1, 24'h080808);
        cyc();
        check("fsv_px_old", data_out, 24'h000000);
        check("fsv_line", line_count, 10'd0);
        check("fsv_mode", mode_active, 2'b01);
        drive(1'b0, 1'b1, 24'h080808);
        cyc();
        check("fsv_newline", line_count, 10'd1);
        check("fsv_px_new", data_out, 24'h101010);
        drive(1'b0, 1'b0, 24'h0);
        cyc();

        // SW=11 behaves as bypass; blank pixels pass through
        SW = 2'b11;
        drive(1'b1, 1'b0, 24'h0);
        cyc();
        check("byp_mode", mode_active, 2'b00);
        drive(1'b0, 1'b0, 24'h123456);
        cyc();
        check("byp_blank", data_out, 24'h123456);
        drive(1'b0, 1'b1, 24'hABCDEF);
        cyc();
        check("byp_vis", data_out, 24'hABCDEF);

        // line counter saturates at all-ones
        for (int i = 0; i < 1030; i++) begin
            drive(1'b0, 1'b0, 24'h0);
            cyc();
            drive(1'b0, 1'b1, 24'h0);
            cyc();
        end
        check("line_sat", line_count, 10'h3FF);
        drive(1'b0, 1'b0, 24'h0);
        cyc();

        // reset in the middle of a diffusion line
        SW = 2'b10;
        drive(1'b1, 1'b0, 24'h0);
        cyc();
        drive(1'b0, 1'b1, 24'h080808);
        cyc();
        check("mr_pre0", data_out, 24'h000000);
        cyc();
        check("mr_pre1", data_out, 24'h101010);
        rst = 1'b0;
        cyc();
        check("mr_data", data_out, 24'h0);
        check("mr_vis", visible_out, 1'b0);
        check("mr_mode", mode_active, 2'b00);
        check("mr_line", line_count, 10'd0);
        rst = 1'b1;
        cyc();
        check("mr_ign_data", data_out, 24'h0);
        check("mr_ign_line", line_count, 10'd0);
        cyc();
        check("mr_ign_line2", line_count, 10'd0);
        SW = 2'b00;
        drive(1'b1, 1'b0, 24'h0);
        cyc();
        drive(1'b0, 1'b1, 24'h555555);
        cyc();
        check("mr_resume_px", data_out, 24'h555555);
        check("mr_resume_line", line_count, 10'd1);
        check("mr_resume_vis", visible_out, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
